nes_pad_emulator: RTL and testbench
===================================

# nes_pad_emulator

Device-side counterpart of the NES controller input receiver. It emulates an NES gamepad's 4021 shift register. It accepts the host's `latch` and `nes_clk` strobes from external pins, samples an 8-bit active-high button vector, and shifts the buttons out serially on `data_out` in active-low NES order. It sits at the board edge: it drives the chip for hardware-in-the-loop test of the receiver path, and lets the design act as a controller for another console or FPGA.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per asynchronous pin input, minimum 2.
- `FILTER_CYCLES`, 4: consecutive stable synchronized cycles required before a pin level is accepted, minimum 1.
- `TIMEOUT_CYCLES`, 2000: cycles without an accepted `nes_clk` rising edge in SHIFT before the frame is aborted. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

- `clk` input 1: system clock, 25 MHz nominal.
- `reset` input 1: asynchronous, active-low reset.
- `latch_in` input 1: raw host latch pin, asynchronous to `clk`.
- `nes_clk_in` input 1: raw host serial clock pin, asynchronous to `clk`.
- `buttons` input 8: 1 = pressed. Bit order: 0 A, 1 B, 2 select, 3 start, 4 up, 5 down, 6 left, 7 right.
- `data_out` output 1: serial data to the host, 0 = pressed. Registered.
- `busy` output 1: high in LOAD and SHIFT.
- `frame_done` output 1: one-cycle pulse when the right bit is presented.
- `timeout_err` output 1: one-cycle pulse when a frame is aborted.

## Operation
- Input conditioning:
  - Each pin passes through `SYNC_STAGES` flops, then a stability filter, then a registered edge detector.
  - The filtered level (`latch_f`, `clk_f`) changes only after the synchronized value has differed from it for `FILTER_CYCLES` consecutive cycles.
  - Shorter pulses are discarded.
  - Both filtered levels reset to 0.
- State register has four states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: `data_out` = 1.
  - LOAD: entered from any state on the `latch_f` rising edge.
    - Each cycle: `shift_reg <= ~buttons` and `data_out <= ~buttons[0]`.
    - The snapshot is the `buttons` value on the last LOAD cycle.
  - SHIFT: entered on the `latch_f` falling edge.
    - Entry: `bit_cnt` = 0 and timeout counter = 0.
    - `data_out` = `shift_reg[0]` (A).
  - In SHIFT, each `clk_f` rising edge:
    - shift right with fill 1 and present the new bit 0 on `data_out`;
    - increment `bit_cnt`;
    - clear the timeout counter.
  - On the 7th rising edge (right presented): go to DONE and pulse `frame_done`.
  - DONE: `data_out` holds right. Any further rising edges shift in 1s, so `data_out` = 1 from the 8th edge on.
  - Timeout: in SHIFT, if the timeout counter reaches `TIMEOUT_CYCLES`, go to IDLE, drive `data_out` = 1 and pulse `timeout_err`.
- Simultaneous events:
  - A `latch_f` rising edge has priority over a `clk_f` edge and over timeout.
  - A `clk_f` edge while `latch_f` is high is ignored; the register stays in parallel load.
- Re-latch mid-SHIFT restarts the frame with no `frame_done` and no `timeout_err`.
- Asserting `reset` at any time, including mid-frame, immediately gives:
  - state IDLE, `data_out` = 1;
  - `busy`, `frame_done`, `timeout_err` = 0;
  - counters, `shift_reg` = 8'hFF, and all sync/filter flops = 0.

## Timing
- Pin edge to `data_out` change: `SYNC_STAGES + FILTER_CYCLES + 1` cycles, which is 7 with the defaults.
- `frame_done` is asserted in the same cycle that `data_out` first shows right.
- `timeout_err` is asserted in the cycle the state leaves SHIFT.
- Minimum accepted host pulse width, high or low: `SYNC_STAGES + FILTER_CYCLES` cycles. The receiver's 150-cycle phases give a large margin.
- `buttons` is sampled synchronously and is not synchronized internally. The driver must hold it stable from the latch rising edge through the latch falling edge plus 7 cycles.

## Structure
- Package `nes_pkg` contains:
  - button index constants (`NES_A` … `NES_RIGHT`);
  - state enum `nes_emu_state_t`;
  - default timing constants shared with the receiver (latch 300 cycles, half-clock 150 cycles).
- Sub-module `nes_input_filter` holds the synchronizer, stability filter and rise/fall pulse outputs. It is instantiated once for latch and once for clock.
- The top level holds the FSM, `shift_reg`, `bit_cnt` and the timeout counter.

## Test plan
Default host waveform: latch high 300 cycles, then 7 nes_clk pulses of 150 cycles high and 150 low.

- Reset with pins low: `data_out`=1, `busy`=0, `frame_done`=0, `timeout_err`=0. Hold for 100 cycles and confirm no change.
- `buttons`=8'h01, default waveform:
  - `data_out` sampled mid-high of each phase reads A..right = 0,1,1,1,1,1,1,1;
  - exactly one `frame_done` pulse, 7 cycles after the 7th `nes_clk_in` rise.
- `buttons`=8'hA5, default waveform: `data_out` = 0,1,0,1,1,0,1,0. An 8th clock pulse makes `data_out` 1.
- 3-cycle glitch on `nes_clk_in` during SHIFT with `FILTER_CYCLES`=4: no shift, and `data_out` stays at the A value.
- Latch only, no clocks: after the latch falls, `timeout_err` pulses `TIMEOUT_CYCLES` cycles after SHIFT entry, then `data_out`=1 and `busy`=0.
- Mid-frame events:
  - re-latch after 3 clocks with `buttons`=8'h80: frame restarts and a full readout gives 1,1,1,1,1,1,1,0, with no spurious `frame_done`;
  - `reset` asserted mid-SHIFT: `data_out`=1 asynchronously.

Source files
------------

// File: rtl/nes_pad_emulator_pkg.sv
// Shared NES pad definitions: button bit positions, emulator states and the
// default host waveform timing also used by the receiver.
package nes_pkg;

  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  localparam int NES_LATCH_CYCLES     = 300;
  localparam int NES_HALF_CLK_CYCLES  = 150;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } nes_emu_state_t;

endpackage

// File: rtl/nes_pad_emulator_if.sv
// Pin-level bundle between an NES host (master) and the pad emulator (slave).
interface nes_pad_emulator_if;
  logic       latch_in;
  logic       nes_clk_in;
  logic [7:0] buttons;
  logic       data_out;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;

  modport master (
    output latch_in, nes_clk_in, buttons,
    input  data_out, busy, frame_done, timeout_err
  );

  modport slave (
    input  latch_in, nes_clk_in, buttons,
    output data_out, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/nes_pad_emulator_input_filter.sv
// Conditions one asynchronous host pin: synchronizer chain, stability filter
// and registered one-cycle rise/fall pulses aligned with the filtered level.
module nes_input_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   level_q, level_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // cnt_q holds how many consecutive cycles the synchronized pin has already
  // disagreed with the accepted level; any agreeing cycle starts it over.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_s != level_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        level_d = sync_s;
        rise_d  = sync_s;
        fall_d  = ~sync_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/nes_pad_emulator.sv
// NES gamepad (4021) emulator: captures buttons on host latch and shifts them
// out active-low on the host serial clock, with frame timeout.
module nes_pad_emulator
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic               clk,
  input  logic               reset,
  nes_pad_emulator_if.slave  pad
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic latch_f, latch_rise, latch_fall;
  logic clk_f, clk_rise, clk_fall;
  logic unused_clk_pins;

  nes_input_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_latch_filter (
    .clk    (clk),
    .rst_n  (reset),
    .pin_i  (pad.latch_in),
    .level_o(latch_f),
    .rise_o (latch_rise),
    .fall_o (latch_fall)
  );

  nes_input_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .clk    (clk),
    .rst_n  (reset),
    .pin_i  (pad.nes_clk_in),
    .level_o(clk_f),
    .rise_o (clk_rise),
    .fall_o (clk_fall)
  );

  assign unused_clk_pins = clk_f ^ clk_fall;

  nes_emu_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           data_q, data_d;
  logic           frame_done_q, frame_done_d;
  logic           timeout_q, timeout_d;
  logic           shift_edge;

  // The serial clock only advances the register once the latch is released.
  assign shift_edge = clk_rise & ~latch_f;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    tcnt_d       = tcnt_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;

    if (latch_rise) begin
      state_d = ST_LOAD;
      shift_d = ~pad.buttons;
      data_d  = ~pad.buttons[NES_A];
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_d = 1'b1;
        end
        ST_LOAD: begin
          shift_d = ~pad.buttons;
          data_d  = ~pad.buttons[NES_A];
          if (latch_fall) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            tcnt_d    = '0;
          end
        end
        ST_SHIFT: begin
          if (shift_edge) begin
            shift_d   = {1'b1, shift_q[7:1]};
            data_d    = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
            tcnt_d    = '0;
            if (bit_cnt_q == 3'(NES_RIGHT - 1)) begin
              state_d      = ST_DONE;
              frame_done_d = 1'b1;
            end
          end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_IDLE;
            data_d    = 1'b1;
            tcnt_d    = '0;
            timeout_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_DONE: begin
          // Extra host clocks drain the 1s shifted in behind the buttons.
          if (shift_edge) begin
            shift_d = {1'b1, shift_q[7:1]};
            data_d  = shift_q[1];
          end
        end
        default: begin
          state_d = ST_IDLE;
          data_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'hFF;
      bit_cnt_q    <= '0;
      tcnt_q       <= '0;
      data_q       <= 1'b1;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tcnt_q       <= tcnt_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign pad.data_out    = data_q;
  assign pad.busy        = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign pad.frame_done  = frame_done_q;
  assign pad.timeout_err = timeout_q;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Directed bench for nes_pad_emulator: table of button frames plus hand-written
// glitch, timeout, re-latch and mid-frame reset sequences.
module tb_nes_pad_emulator;
  import nes_pkg::*;

  localparam int TIMEOUT = 2000;
  localparam int LAT     = 7;   // pin edge to data_out change, default params
  localparam int HALF    = NES_HALF_CLK_CYCLES;
  localparam int LATCH   = NES_LATCH_CYCLES;

  typedef struct {
    logic [7:0] buttons;
    logic [7:0] serial;   // bit i = data_out expected for the i-th bit read
  } vec_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   fd_count = 0;
  int   te_count = 0;

  nes_pad_emulator_if pad ();

  nes_pad_emulator dut (
    .clk  (clk),
    .reset(reset),
    .pad  (pad)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (pad.frame_done === 1'b1)  fd_count++;
    if (pad.timeout_err === 1'b1) te_count++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_latch(output logic a_mid, output logic busy_mid);
    pad.latch_in = 1'b1;
    cycles(HALF);
    a_mid    = pad.data_out;
    busy_mid = pad.busy;
    cycles(LATCH - HALF);
    pad.latch_in = 1'b0;
    cycles(HALF);
  endtask

  task automatic do_pulse(output logic mid, output int fd_at);
    fd_at = -1;
    mid   = 1'bx;
    pad.nes_clk_in = 1'b1;
    for (int i = 1; i <= HALF; i++) begin
      cycles(1);
      if (pad.frame_done === 1'b1 && fd_at < 0) fd_at = i;
      if (i == HALF / 2) mid = pad.data_out;
    end
    pad.nes_clk_in = 1'b0;
    cycles(HALF);
  endtask

  vec_t vecs[6];

  initial begin
    logic       a, b, m, bad;
    logic [7:0] got;
    int         fd, te_at;

    vecs[0] = '{buttons: 8'h01, serial: 8'hFE};
    vecs[1] = '{buttons: 8'hA5, serial: 8'h5A};
    vecs[2] = '{buttons: 8'hFF, serial: 8'h00};
    vecs[3] = '{buttons: 8'h00, serial: 8'hFF};
    vecs[4] = '{buttons: 8'h80, serial: 8'h7F};
    vecs[5] = '{buttons: 8'h3C, serial: 8'hC3};

    pad.latch_in   = 1'b0;
    pad.nes_clk_in = 1'b0;
    pad.buttons    = 8'h00;
    reset          = 1'b0;

    // Reset state, then idle hold with pins low
    cycles(3);
    check("rst data_out", pad.data_out, 1'b1);
    check("rst busy", pad.busy, 1'b0);
    check("rst frame_done", pad.frame_done, 1'b0);
    check("rst timeout_err", pad.timeout_err, 1'b0);
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (pad.data_out !== 1'b1 || pad.busy !== 1'b0 ||
          pad.frame_done !== 1'b0 || pad.timeout_err !== 1'b0) bad = 1'b1;
    end
    check("idle hold", bad, 1'b0);

    // Table-driven full frames
    for (int v = 0; v < 6; v++) begin
      pad.buttons = vecs[v].buttons;
      fd_count = 0;
      te_count = 0;
      do_latch(a, b);
      check($sformatf("vec%0d bit0", v), a, vecs[v].serial[0]);
      check($sformatf("vec%0d busy load", v), b, 1'b1);
      for (int k = 1; k < 8; k++) begin
        do_pulse(m, fd);
        check($sformatf("vec%0d bit%0d", v, k), m, vecs[v].serial[k]);
        if (k == 7) check($sformatf("vec%0d frame_done latency", v), fd, LAT);
      end
      check($sformatf("vec%0d frame_done count", v), fd_count, 1);
      check($sformatf("vec%0d timeout count", v), te_count, 0);
      check($sformatf("vec%0d busy done", v), pad.busy, 1'b0);
      do_pulse(m, fd);
      check($sformatf("vec%0d 8th bit", v), m, 1'b1);
    end

    // 3-cycle glitch on nes_clk_in during SHIFT must not shift
    pad.buttons = 8'h02;
    fd_count = 0;
    do_latch(a, b);
    check("glitch A before", a, 1'b1);
    pad.nes_clk_in = 1'b1;
    cycles(3);
    pad.nes_clk_in = 1'b0;
    cycles(30);
    check("glitch A held", pad.data_out, 1'b1);
    do_pulse(m, fd);
    check("glitch B after", m, 1'b0);
    for (int k = 2; k < 8; k++) do_pulse(m, fd);
    check("glitch frame_done count", fd_count, 1);

    // Latch without clocks: timeout
    pad.buttons = 8'h01;
    fd_count = 0;
    te_count = 0;
    pad.latch_in = 1'b1;
    cycles(LATCH);
    pad.latch_in = 1'b0;
    te_at = -1;
    for (int i = 1; i <= TIMEOUT + 40; i++) begin
      cycles(1);
      if (i == TIMEOUT) begin
        check("timeout pre data_out", pad.data_out, 1'b0);
        check("timeout pre busy", pad.busy, 1'b1);
      end
      if (pad.timeout_err === 1'b1 && te_at < 0) te_at = i;
    end
    check("timeout latency", te_at, TIMEOUT + LAT);
    check("timeout count", te_count, 1);
    check("timeout data_out", pad.data_out, 1'b1);
    check("timeout busy", pad.busy, 1'b0);
    check("timeout no frame_done", fd_count, 0);

    // Re-latch after 3 clocks restarts the frame
    pad.buttons = 8'h01;
    fd_count = 0;
    te_count = 0;
    do_latch(a, b);
    for (int k = 0; k < 3; k++) do_pulse(m, fd);
    pad.buttons = 8'h80;
    do_latch(a, b);
    got = 8'h00;
    got[0] = a;
    for (int k = 1; k < 8; k++) begin
      do_pulse(m, fd);
      got[k] = m;
    end
    check("relatch readout", got, 8'h7F);
    check("relatch frame_done count", fd_count, 1);
    check("relatch timeout count", te_count, 0);

    // Reset asserted mid-SHIFT acts without a clock edge
    pad.buttons = 8'h01;
    do_latch(a, b);
    check("midrst pre data_out", pad.data_out, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst data_out async", pad.data_out, 1'b1);
    check("midrst busy async", pad.busy, 1'b0);
    cycles(2);
    reset = 1'b1;
    cycles(20);
    check("midrst idle data_out", pad.data_out, 1'b1);
    check("midrst idle busy", pad.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
